// File: rtl/prv664_bus_define.sv
// Shared AXI bus definitions: B/R response encodings and the default ID width.
package prv664_bus_define;

  localparam int BUS_ID_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; push while full and
// pop while empty are ignored. Storage is not reset.
module bus_sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [AW:0]      w_wr_nxt, w_rd_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_full, r_empty;
  logic             w_push, w_pop;
  logic             w_full_nxt, w_empty_nxt;

  assign w_push = push_i && !r_full;
  assign w_pop  = pop_i && !r_empty;

  assign w_wr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_full_nxt  = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                       (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
  assign w_empty_nxt = (w_wr_nxt == w_rd_nxt);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_full   <= w_full_nxt;
      r_empty  <= w_empty_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din_i;
  end

  assign dout_o  = r_mem[r_rd_ptr[AW-1:0]];
  assign full_o  = r_full;
  assign empty_o = r_empty;

endmodule

// File: rtl/axi_b_resp_gen.sv
// Slave-side AXI write-response generator: pairs accepted AW IDs with W
// completions in order and issues one B response per burst.
module axi_b_resp_gen
  import prv664_bus_define::*;
#(
  parameter int ID_W  = BUS_ID_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     aw_fire_i,
  input  logic [ID_W-1:0]          aw_id_i,
  output logic                     aw_ready_o,
  input  logic                     wdone_valid_i,
  input  logic                     wdone_err_i,
  output logic                     wdone_ready_o,
  output logic [ID_W-1:0]          bid_o,
  output logic [1:0]               bresp_o,
  output logic                     bvalid_o,
  input  logic                     bready_i,
  output logic [$clog2(DEPTH):0]   pending_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            w_id_full, w_id_empty, w_d_full, w_d_empty;
  logic [ID_W-1:0] w_id_head;
  logic            w_err_head;
  logic            w_aw_push, w_b_hs, w_load;

  logic            r_bvalid;
  logic [ID_W-1:0] r_bid;
  logic [1:0]      r_bresp;
  logic [CW-1:0]   r_pending;

  assign w_aw_push = aw_fire_i && !w_id_full;
  assign w_b_hs    = r_bvalid && bready_i;
  // The output register reloads when empty or being drained this cycle.
  assign w_load    = !w_id_empty && !w_d_empty && (!r_bvalid || bready_i);

  bus_sync_fifo #(.WIDTH(ID_W), .DEPTH(DEPTH)) u_id_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (aw_fire_i),
    .din_i   (aw_id_i),
    .pop_i   (w_load),
    .dout_o  (w_id_head),
    .full_o  (w_id_full),
    .empty_o (w_id_empty)
  );

  bus_sync_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_done_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (wdone_valid_i),
    .din_i   (wdone_err_i),
    .pop_i   (w_load),
    .dout_o  (w_err_head),
    .full_o  (w_d_full),
    .empty_o (w_d_empty)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_bvalid <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= RESP_OKAY;
    end else if (w_load) begin
      r_bvalid <= 1'b1;
      r_bid    <= w_id_head;
      r_bresp  <= resp_of(w_err_head);
    end else if (w_b_hs) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_pending <= '0;
    end else begin
      case ({w_aw_push, w_b_hs})
        2'b10:   r_pending <= r_pending + CW'(1);
        2'b01:   r_pending <= r_pending - CW'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (arst_i) aw_fire_i |-> !w_id_full);

  assign aw_ready_o    = !w_id_full;
  assign wdone_ready_o = !w_d_full;
  assign bvalid_o      = r_bvalid;
  assign bid_o         = r_bid;
  assign bresp_o       = r_bresp;
  assign pending_o     = r_pending;

endmodule

// File: tb/tb_axi_b_resp_gen.sv
// Directed bench for axi_b_resp_gen (ID_W=4, DEPTH=4); inputs change 1ns
// after each rising edge and outputs are sampled at that same point.
module tb_axi_b_resp_gen;

  logic       clk_i = 1'b0;
  logic       arst_i = 1'b1;
  logic       aw_fire_i = 1'b0;
  logic [3:0] aw_id_i = '0;
  logic       aw_ready_o;
  logic       wdone_valid_i = 1'b0;
  logic       wdone_err_i = 1'b0;
  logic       wdone_ready_o;
  logic [3:0] bid_o;
  logic [1:0] bresp_o;
  logic       bvalid_o;
  logic       bready_i = 1'b0;
  logic [2:0] pending_o;

  int tests = 0;
  int fails = 0;

  axi_b_resp_gen #(.ID_W(4), .DEPTH(4)) dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .aw_fire_i     (aw_fire_i),
    .aw_id_i       (aw_id_i),
    .aw_ready_o    (aw_ready_o),
    .wdone_valid_i (wdone_valid_i),
    .wdone_err_i   (wdone_err_i),
    .wdone_ready_o (wdone_ready_o),
    .bid_o         (bid_o),
    .bresp_o       (bresp_o),
    .bvalid_o      (bvalid_o),
    .bready_i      (bready_i),
    .pending_o     (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic aw, input logic [3:0] id, input logic wd, input logic err);
    aw_fire_i     = aw;
    aw_id_i       = id;
    wdone_valid_i = wd;
    wdone_err_i   = err;
    @(posedge clk_i);
    #1;
    aw_fire_i     = 1'b0;
    wdone_valid_i = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ids [10];
    logic       errs [10];
    int na, nw, nb, guard;

    // 1: reset
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("rst_bvalid", bvalid_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_aw_ready", aw_ready_o, 1);
    chk("rst_wd_ready", wdone_ready_o, 1);
    chk("rst_bid", bid_o, 0);
    chk("rst_bresp", bresp_o, 0);
    arst_i = 1'b0;
    idle();

    // 2: AW id 3, then W two edges later
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    chk("t2_pending1", pending_o, 1);
    chk("t2_bvalid_early", bvalid_o, 0);
    idle();
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("t2_bvalid_wpush", bvalid_o, 0);
    bready_i = 1'b1;
    idle();
    chk("t2_bvalid", bvalid_o, 1);
    chk("t2_bid", bid_o, 3);
    chk("t2_bresp", bresp_o, 2'b00);
    chk("t2_pending_hold", pending_o, 1);
    idle();
    chk("t2_bvalid_drop", bvalid_o, 0);
    chk("t2_pending0", pending_o, 0);

    // 3: W error completes before its AW
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    idle();
    idle();
    chk("t3_wait_bvalid", bvalid_o, 0);
    chk("t3_wait_pending", pending_o, 0);
    cyc(1'b1, 4'd5, 1'b0, 1'b0);
    chk("t3_bvalid_awpush", bvalid_o, 0);
    chk("t3_pending1", pending_o, 1);
    idle();
    chk("t3_bvalid", bvalid_o, 1);
    chk("t3_bid", bid_o, 5);
    chk("t3_bresp", bresp_o, 2'b10);
    idle();
    chk("t3_bvalid_drop", bvalid_o, 0);
    chk("t3_pending0", pending_o, 0);

    // 4: backpressure
    bready_i = 1'b0;
    cyc(1'b1, 4'd1, 1'b1, 1'b0);
    chk("t4_pending1", pending_o, 1);
    cyc(1'b1, 4'd2, 1'b1, 1'b0);
    chk("t4_bid1", bid_o, 1);
    cyc(1'b1, 4'd3, 1'b1, 1'b0);
    cyc(1'b1, 4'd4, 1'b1, 1'b0);
    chk("t4_aw_ready_3q", aw_ready_o, 1);
    chk("t4_pending4", pending_o, 4);
    cyc(1'b1, 4'd5, 1'b0, 1'b0);
    chk("t4_aw_ready_full", aw_ready_o, 0);
    chk("t4_pending5", pending_o, 5);
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("t4_hold_bvalid", bvalid_o, 1);
      chk("t4_hold_bid", bid_o, 1);
    end
    bready_i = 1'b1;
    idle();
    chk("t4_rel_bid2", bid_o, 2);
    chk("t4_rel_bvalid2", bvalid_o, 1);
    chk("t4_rel_aw_ready", aw_ready_o, 1);
    chk("t4_rel_pending4", pending_o, 4);
    idle();
    chk("t4_rel_bid3", bid_o, 3);
    idle();
    chk("t4_rel_bid4", bid_o, 4);
    chk("t4_rel_pending2", pending_o, 2);
    idle();
    chk("t4_rel_drop", bvalid_o, 0);
    chk("t4_rel_pending1", pending_o, 1);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    idle();
    chk("t4_bid5", bid_o, 5);
    chk("t4_bvalid5", bvalid_o, 1);
    idle();
    chk("t4_end_pending", pending_o, 0);

    // 5a: full ID FIFO, then pop and push in the same cycles
    cyc(1'b1, 4'd6, 1'b0, 1'b0);
    cyc(1'b1, 4'd7, 1'b0, 1'b0);
    cyc(1'b1, 4'd8, 1'b0, 1'b0);
    cyc(1'b1, 4'd9, 1'b0, 1'b0);
    chk("t5_full_aw_ready", aw_ready_o, 0);
    chk("t5_full_pending", pending_o, 4);
    chk("t5_full_bvalid", bvalid_o, 0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("t5_a_bvalid", bvalid_o, 0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("t5_b_bid6", bid_o, 6);
    chk("t5_b_bresp", bresp_o, 2'b00);
    chk("t5_b_aw_ready", aw_ready_o, 1);
    cyc(1'b1, 4'd10, 1'b1, 1'b0);
    chk("t5_c_bid7", bid_o, 7);
    chk("t5_c_bresp", bresp_o, 2'b10);
    chk("t5_c_pending", pending_o, 4);
    cyc(1'b1, 4'd11, 1'b1, 1'b0);
    chk("t5_d_bid8", bid_o, 8);
    chk("t5_d_bresp", bresp_o, 2'b00);
    chk("t5_d_pending", pending_o, 4);
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("t5_e_bid9", bid_o, 9);
    chk("t5_e_bresp", bresp_o, 2'b00);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("t5_f_bid10", bid_o, 10);
    chk("t5_f_bresp", bresp_o, 2'b10);
    idle();
    chk("t5_g_bid11", bid_o, 11);
    chk("t5_g_bresp", bresp_o, 2'b00);
    idle();
    chk("t5_h_bvalid", bvalid_o, 0);
    chk("t5_h_pending", pending_o, 0);

    // 5b: ten random bursts with random handshakes across pointer wrap
    for (int i = 0; i < 10; i++) begin
      ids[i]  = 4'((i * 7 + 2) % 16);
      errs[i] = 1'($urandom_range(0, 1));
    end
    na = 0; nw = 0; nb = 0; guard = 0;
    while (nb < 10 && guard < 400) begin
      aw_fire_i = (na < 10) && aw_ready_o && ($urandom_range(0, 3) != 0);
      aw_id_i   = (na < 10) ? ids[na] : 4'h0;
      if (aw_fire_i) na++;
      wdone_valid_i = (nw < 10) && wdone_ready_o && ($urandom_range(0, 3) != 0);
      wdone_err_i   = (nw < 10) ? errs[nw] : 1'b0;
      if (wdone_valid_i) nw++;
      bready_i = ($urandom_range(0, 2) != 0);
      if (bvalid_o && bready_i) begin
        chk("t5_rand_bid", bid_o, ids[nb]);
        chk("t5_rand_bresp", bresp_o, errs[nb] ? 2'b10 : 2'b00);
        nb++;
      end
      @(posedge clk_i); #1;
      guard++;
    end
    aw_fire_i = 1'b0;
    wdone_valid_i = 1'b0;
    chk("t5_rand_count", nb, 10);
    chk("t5_rand_pending", pending_o, 0);
    bready_i = 1'b0;
    idle();
    chk("t5_rand_bvalid", bvalid_o, 0);

    // 6: reset with a response in flight and two bursts pending
    cyc(1'b1, 4'd1, 1'b1, 1'b0);
    cyc(1'b1, 4'd2, 1'b1, 1'b1);
    chk("t6_pre_bvalid", bvalid_o, 1);
    chk("t6_pre_pending", pending_o, 2);
    arst_i = 1'b1;
    #1;
    chk("t6_async_bvalid", bvalid_o, 0);
    chk("t6_async_pending", pending_o, 0);
    chk("t6_async_aw_ready", aw_ready_o, 1);
    @(posedge clk_i); #1;
    arst_i = 1'b0;
    bready_i = 1'b1;
    idle();
    chk("t6_stale_bvalid", bvalid_o, 0);
    cyc(1'b1, 4'd7, 1'b1, 1'b0);
    idle();
    chk("t6_fresh_bvalid", bvalid_o, 1);
    chk("t6_fresh_bid", bid_o, 7);
    chk("t6_fresh_bresp", bresp_o, 2'b00);
    idle();
    chk("t6_end_bvalid", bvalid_o, 0);
    chk("t6_end_pending", pending_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
